clk_div_prog: RTL and testbench

Parametrised, runtime-programmable multi-channel clock divider that generates 50%-duty divided clocks and single-cycle period strobes from the 50 MHz system clock. Channel 0 is frequency-programmed: a sequential restoring divider converts a requested output frequency into a half-period count. Channels 1..CH-1 take their half-period directly. All divisor changes take effect glitch-free at a toggle boundary. The block feeds the DAC sample clock (channel 0) and fixed-rate consumers such as UART oversampling and display scan.

---
 rtl/clk_div_prog.sv | 217 +++++++++++++++++++++
 tb/tb_clk_div_prog.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
//
// Runtime-programmable multi-channel clock divider. Every channel produces a
// 50%-duty divided clock and a one-cycle strobe on each rising edge of that
// clock. The output period is 2*H system cycles, where H is the channel's
// active half-period.
//
// Channel 0 is frequency-programmed. A small FSM turns the requested waveform
// frequency into a half-period with a sequential restoring divider:
//   H0 = CLK_HZ / (freq * 2 * STEPS), clamped to [1, 2^CNT_W-1]
// freq = 0 halts channel 0 and runs no division.
// Channels 1..CH-1 take their half-period directly from div_half.
//
// A new half-period only reaches a channel on that channel's toggle edge, or
// on the next edge if the channel is halted. A running phase is therefore
// never cut short, so changing the divisor cannot produce a glitch.
//
// Handshake: this block has no valid/ready pair. busy is high while a division
// is running. The divider result is written to the channel-0 pending register
// on the same edge that busy falls. half0 shows the half-period channel 0 is
// currently using, not the pending one.
//
// Ports
//   clk        in   1               system clock, rising edge
//   rst_n      in   1               asynchronous active-low reset
//   freq       in   FREQ_W          channel-0 waveform frequency in Hz, 0 = halt
//   div_half   in   (CH-1)*CNT_W    half-periods of channels 1..CH-1, 0 = halt;
//                                   channel i at [(i-1)*CNT_W +: CNT_W]
//   clk_out    out  CH              divided clocks
//   tick       out  CH              strobe on each 0->1 edge of clk_out
//   busy       out  1               divider is computing
//   half0      out  CNT_W           half-period applied to channel 0
//   dbg_state  out  1               frequency-calculator FSM state (1 = CALC)
// -----------------------------------------------------------------------------
module clk_div_prog #(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned STEPS  = 4096,
  parameter int unsigned CH     = 3,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned FREQ_W = 8,
  parameter int unsigned DIV_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [FREQ_W-1:0]         freq,
  input  logic [(CH-1)*CNT_W-1:0]   div_half,
  output logic [CH-1:0]             clk_out,
  output logic [CH-1:0]             tick,
  output logic                      busy,
  output logic [CNT_W-1:0]          half0,
  output logic                      dbg_state
);

  // Shifting freq left by log2(2*STEPS) multiplies it by 2*STEPS, giving the
  // divisor. STEPS is a power of two.
  localparam int unsigned       SHIFT    = $clog2(2 * STEPS);
  localparam int unsigned       IT_W     = $clog2(DIV_W);
  localparam logic [IT_W-1:0]   IT_LAST  = IT_W'(DIV_W - 1);
  localparam logic [DIV_W-1:0]  DIVIDEND = DIV_W'(CLK_HZ);
  localparam logic [CNT_W-1:0]  H_MAX    = '1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_CALC = 1'b1
  } calc_state_t;

  calc_state_t        state;
  logic [FREQ_W-1:0]  last_freq;
  logic [DIV_W-1:0]   divisor;
  logic [DIV_W-1:0]   dvd;       // dividend; bits leave through the MSB
  logic [DIV_W-1:0]   rem;       // partial remainder, always < divisor
  logic [DIV_W-1:0]   quo;       // quotient; bits enter at the LSB
  logic [IT_W-1:0]    iter;
  logic [CNT_W-1:0]   pend0;     // next half-period for channel 0

  // ---------------------------------------------------------------------------
  // One restoring-division step. The remainder is shifted left and the next
  // dividend bit is brought in. The divisor is subtracted only when it fits.
  // rem_sh needs one extra bit because it can reach 2*divisor-1.
  // ---------------------------------------------------------------------------
  logic [DIV_W:0]     rem_sh;
  logic [DIV_W-1:0]   rem_sub;
  logic               q_bit;
  logic [DIV_W-1:0]   rem_next;
  logic [DIV_W-1:0]   quo_next;
  logic [CNT_W-1:0]   q_clamped;

  always_comb begin
    rem_sh   = {rem, dvd[DIV_W-1]};
    q_bit    = (rem_sh >= {1'b0, divisor});
    // When q_bit is set the difference is below divisor, so the low DIV_W bits
    // hold it exactly.
    rem_sub  = rem_sh[DIV_W-1:0] - divisor;
    rem_next = q_bit ? rem_sub : rem_sh[DIV_W-1:0];
    quo_next = {quo[DIV_W-2:0], q_bit};
  end

  // The quotient is clamped so that it always fits the counter. It is also
  // kept at least 1, because a non-zero frequency must never look like a halt.
  always_comb begin
    if (quo_next == '0) begin
      q_clamped = CNT_W'(1);
    end else if (quo_next > DIV_W'(H_MAX)) begin
      q_clamped = H_MAX;
    end else begin
      q_clamped = quo_next[CNT_W-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Frequency calculator. A freq change seen during CALC is not lost: the
  // running division completes, then the IDLE compare sees the new value and
  // starts another division. The most recent value is the one that wins.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      last_freq <= '0;
      divisor   <= '0;
      dvd       <= '0;
      rem       <= '0;
      quo       <= '0;
      iter      <= '0;
      pend0     <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (freq != last_freq) begin
            last_freq <= freq;
            if (freq == '0) begin
              pend0 <= '0;
            end else begin
              divisor <= DIV_W'(freq) << SHIFT;
              dvd     <= DIVIDEND;
              rem     <= '0;
              quo     <= '0;
              iter    <= '0;
              busy    <= 1'b1;
              state   <= S_CALC;
            end
          end
        end
        S_CALC: begin
          rem  <= rem_next;
          quo  <= quo_next;
          dvd  <= {dvd[DIV_W-2:0], 1'b0};
          iter <= iter + IT_W'(1);
          if (iter == IT_LAST) begin
            pend0 <= q_clamped;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign dbg_state = (state == S_CALC);

  // ---------------------------------------------------------------------------
  // Per-channel half-period counters.
  //   h == 0 : halted. The output is held low and the pending value is
  //            reloaded every cycle, so a restart begins at once.
  //   wrap   : the output toggles, the counter clears, and the pending value
  //            is loaded. Loading only here keeps every phase full length.
  //            The >= compare makes the wrap safe even if h is ever smaller
  //            than the current count.
  // A wrap that loads 0 stops the channel. If the output is high at that
  // moment, the h == 0 branch drives it low on the next edge.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < CH; g++) begin : g_ch
    logic [CNT_W-1:0] pend;
    logic [CNT_W-1:0] h;
    logic [CNT_W-1:0] cnt;
    logic             out_q;
    logic             tick_q;

    if (g == 0) begin : g_src0
      assign pend  = pend0;
      assign half0 = h;
    end else begin : g_srcn
      assign pend = div_half[(g-1)*CNT_W +: CNT_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        h      <= '0;
        cnt    <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
      end else if (h == '0) begin
        cnt    <= '0;
        out_q  <= 1'b0;
        tick_q <= 1'b0;
        h      <= pend;
      end else if (cnt >= h - CNT_W'(1)) begin
        cnt    <= '0;
        out_q  <= ~out_q;
        tick_q <= ~out_q;      // strobe only on the 0->1 toggle
        h      <= pend;
      end else begin
        cnt    <= cnt + CNT_W'(1);
        tick_q <= 1'b0;
      end
    end

    assign clk_out[g] = out_q;
    assign tick[g]    = tick_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// -----------------------------------------------------------------------------
// Bench for clk_div_prog. The stimulus side pushes expected channel-0
// half-periods and busy pulse lengths into queues. A monitor running on the
// falling clock edge pops those queues and compares them with the DUT. The
// monitor also measures every clk_out phase and checks each tick.
// Each phase is checked against the half-period the bench itself supplied
// at the edge that started that phase.
// -----------------------------------------------------------------------------
module tb_clk_div_prog;

  localparam int CLK_HZ = 50_000_000;
  localparam int STEPS  = 4096;
  localparam int CH     = 3;
  localparam int CNT_W  = 16;
  localparam int FREQ_W = 8;
  localparam int DIV_W  = 32;

  // ---------------- clock / reset ----------------
  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [FREQ_W-1:0]       freq = '0;
  logic [(CH-1)*CNT_W-1:0] div_half = '0;
  logic [CH-1:0]           clk_out;
  logic [CH-1:0]           tick;
  logic                    busy;
  logic [CNT_W-1:0]        half0;
  logic                    dbg_state;

  always #5 clk = ~clk;

  clk_div_prog #(
    .CLK_HZ(CLK_HZ), .STEPS(STEPS), .CH(CH),
    .CNT_W(CNT_W), .FREQ_W(FREQ_W), .DIV_W(DIV_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .freq(freq), .div_half(div_half),
    .clk_out(clk_out), .tick(tick), .busy(busy), .half0(half0),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [CNT_W-1:0] h0_exp_q[$];
  logic [31:0]      busy_exp_q[$];

  int unsigned model_last = 0;  // last freq the divider has accepted
  int unsigned model_h0   = 0;  // half0 expected once things settle

  task automatic check(input string name, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: half-period = CLK_HZ / (f * 2 * STEPS), clamped to [1, 2^CNT_W-1]
  function automatic int unsigned model_half(input int unsigned f);
    longint unsigned q;
    longint unsigned hmax;
    if (f == 0) return 0;
    hmax = (longint'(1) << CNT_W) - 1;
    q = longint'(CLK_HZ) / (longint'(f) * 2 * STEPS);
    if (q < 1) q = 1;
    if (q > hmax) q = hmax;
    return int'(q);
  endfunction

  // Record what the divider will do when it accepts f (the DUT must be idle).
  task automatic expect_change(input int unsigned f);
    int unsigned h;
    if (f != model_last) begin
      if (f != 0) busy_exp_q.push_back(32'(DIV_W));
      h = model_half(f);
      if (h != model_h0) h0_exp_q.push_back(CNT_W'(h));
      model_h0   = h;
      model_last = f;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_freq(input int unsigned f);
    freq = FREQ_W'(f);
    expect_change(f);
  endtask

  task automatic set_dh(input int ch, input int unsigned v);
    div_half[(ch-1)*CNT_W +: CNT_W] = CNT_W'(v);
  endtask

  task automatic wait_tick(input int ch, input int bound);
    int k = 0;
    while (tick[ch] !== 1'b1 && k < bound) begin
      @(negedge clk);
      k++;
    end
    check($sformatf("wait_tick%0d", ch), tick[ch], 1);
  endtask

  task automatic hold_low(input int ch, input int n);
    int seen = 0;
    repeat (n) begin
      @(negedge clk);
      if (clk_out[ch] !== 1'b0 || tick[ch] !== 1'b0) seen++;
    end
    check($sformatf("hold_low%0d", ch), seen, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_clk_out"}, clk_out, 0);
    check({tag, "_tick"},    tick,    0);
    check({tag, "_busy"},    busy,    0);
    check({tag, "_half0"},   half0,   0);
  endtask

  // ---------------- monitor ----------------
  logic [(CH-1)*CNT_W-1:0] dh_at_edge = '0;
  always @(posedge clk) dh_at_edge <= div_half;

  int               phase_len[CH];
  int               phase_exp[CH];   // 0 = phase not measured
  logic [CH-1:0]    prev_clk = '0;
  logic [CNT_W-1:0] prev_h0 = '0;
  logic             prev_busy = 1'b0;
  int               busy_run = 0;
  int               cur_exp_h0 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_clk   = '0;
      prev_h0    = '0;
      prev_busy  = 1'b0;
      busy_run   = 0;
      cur_exp_h0 = 0;
      for (int i = 0; i < CH; i++) begin
        phase_len[i] = 0;
        phase_exp[i] = 0;
      end
    end else begin
      if (half0 !== prev_h0) begin
        if (h0_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL half0_unexpected: got %0d expected no change from %0d at %0t",
                   half0, prev_h0, $time);
        end else begin
          cur_exp_h0 = int'(h0_exp_q.pop_front());
          check("half0", half0, cur_exp_h0);
        end
        if (prev_h0 != 0) check("half0_at_toggle", clk_out[0] != prev_clk[0], 1);
      end
      if (busy) begin
        busy_run++;
      end else if (prev_busy) begin
        if (busy_exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL busy_unexpected: got pulse of %0d expected none at %0t",
                   busy_run, $time);
        end else begin
          check("busy_len", busy_run, busy_exp_q.pop_front());
        end
        busy_run = 0;
      end
      for (int i = 0; i < CH; i++) begin
        if (tick[i] || (clk_out[i] && !prev_clk[i]))
          check($sformatf("tick%0d", i), tick[i], clk_out[i] & ~prev_clk[i]);
        if (clk_out[i] !== prev_clk[i]) begin
          if (phase_exp[i] != 0)
            check($sformatf("phase%0d", i), phase_len[i], phase_exp[i]);
          if (i == 0) phase_exp[i] = cur_exp_h0;
          else        phase_exp[i] = int'(dh_at_edge[(i-1)*CNT_W +: CNT_W]);
          phase_len[i] = 1;
        end else begin
          phase_len[i]++;
        end
      end
      prev_clk  = clk_out;
      prev_h0   = half0;
      prev_busy = busy;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int unsigned f;
    int unsigned old_h;

    // Reset state, with freq = 100 and channel 1 set for a 9600x16 clock.
    freq = 8'd100;
    set_dh(1, 163);
    set_dh(2, 7);
    cycles(3);
    check_all_zero("reset");
    expect_change(100);
    @(posedge clk); #3 rst_n = 1'b1;
    cycles(700);                       // 32-cycle busy, then half0 = 61, period 122

    // 100 -> 255 while running: half0 becomes 23 only at a toggle edge
    set_freq(255);
    cycles(400);

    // Halt channel 0 at the start of a high phase; it must then stay low
    wait_tick(0, 200);
    set_freq(0);
    cycles(60);
    hold_low(0, 200);

    // 100 -> 50 -> 200 inside one CALC: two divisions, final half0 = 30
    freq = 8'd100;
    expect_change(100);
    cycles(5);
    freq = 8'd50;
    cycles(5);
    freq = 8'd200;
    busy_exp_q.push_back(32'(DIV_W));
    h0_exp_q.push_back(CNT_W'(model_half(200)));
    model_h0   = model_half(200);
    model_last = 200;
    cycles(400);

    // freq = 1: half0 saturates the usual range at 6103
    old_h = model_h0;
    set_freq(1);
    cycles(50 + 2 * old_h + 2 * 6103);
    old_h = model_h0;
    set_freq(100);
    cycles(50 + 2 * old_h + 2 * 61);

    // Channel 1: shrink to 5 part-way through a phase, then halt it low
    wait_tick(1, 400);
    cycles(100);
    set_dh(1, 5);
    cycles(300);
    wait_tick(1, 50);
    set_dh(1, 0);
    cycles(10);
    hold_low(1, 100);
    set_dh(1, 163);
    cycles(700);

    // Randomised frequencies and direct half-periods
    for (int it = 0; it < 10; it++) begin
      old_h = model_h0;
      f = $urandom_range(20, 255);
      set_freq(f);
      cycles($urandom_range(0, 40));
      set_dh(1, $urandom_range(1, 300));
      set_dh(2, $urandom_range(1, 300));
      cycles(60 + 2 * old_h + 3 * model_h0);
    end

    // Asynchronous reset in the middle of a division and of running periods
    f = (model_last == 150) ? 151 : 150;
    set_freq(f);
    cycles(10);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_all_zero("midcalc_reset");
    h0_exp_q.delete();
    busy_exp_q.delete();
    model_h0   = 0;
    model_last = 0;
    cycles(4);
    check_all_zero("held_reset");
    expect_change(f);
    @(posedge clk); #3 rst_n = 1'b1;
    cycles(60 + 3 * model_h0 + 400);

    check("h0_queue_empty",   h0_exp_q.size(),   0);
    check("busy_queue_empty", busy_exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
